// File: rtl/serial_frame_pkg.sv
// Shared types and line levels for the serial frame transmit/receive pair.
package serial_frame_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/serial_frame_tx_if.sv
// Parallel-word handshake plus serial line of the frame transmitter.
interface serial_frame_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              tx_out;
    logic              busy;

    modport master (output in_data, in_valid, input in_ready, tx_out, busy);
    modport slave  (input in_data, in_valid, output in_ready, tx_out, busy);
endinterface

// File: rtl/serial_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, flags the last cycle, restarts itself.
module serial_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tc
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CNT_W-1:0] count_q;

    assign tc = (count_q == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear || tc) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 1'b1;
        end
    end
endmodule

// File: rtl/serial_frame_tx.sv
// Framed serial transmitter: start bit, LSB-first data, optional parity, stop bit.
//
// state  | meaning
// IDLE   | line high, in_ready asserted, waiting for a word
// START  | driving the start bit (0)
// DATA   | driving shift_q[0], one data bit per bit period
// PARITY | driving the stored parity bit
// STOP   | driving the stop bit (1), then back to IDLE
module serial_frame_tx
    import serial_frame_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_frame_tx_if.slave  bus
);
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q;
    logic              par_q;
    logic [BIT_W-1:0]  bit_idx_q;
    logic              bit_end;
    logic              accept;
    logic              last_bit;

    assign accept   = bus.in_valid && bus.in_ready;
    assign last_bit = (bit_idx_q == BIT_W'(DATA_W - 1));

    // Held cleared in IDLE so every frame starts on a fresh bit period.
    serial_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state_q == IDLE),
        .tc    (bit_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = START;
            START:   if (bit_end) state_d = DATA;
            DATA:    if (bit_end && last_bit) state_d = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY:  if (bit_end) state_d = STOP;
            STOP:    if (bit_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q   <= '0;
            par_q     <= 1'b0;
            bit_idx_q <= '0;
        end else if (accept) begin
            shift_q   <= bus.in_data;
            par_q     <= (^bus.in_data) ^ (PARITY_ODD != 0);
            bit_idx_q <= '0;
        end else if (state_q == DATA && bit_end) begin
            shift_q   <= shift_q >> 1;
            bit_idx_q <= last_bit ? '0 : bit_idx_q + 1'b1;
        end
    end

    // Line level comes from registers only, so input glitches never reach tx_out.
    always_comb begin
        bus.tx_out = LINE_IDLE;
        case (state_q)
            IDLE:    bus.tx_out = LINE_IDLE;
            START:   bus.tx_out = LINE_START;
            DATA:    bus.tx_out = shift_q[0];
            PARITY:  bus.tx_out = par_q;
            STOP:    bus.tx_out = LINE_IDLE;
            default: bus.tx_out = LINE_IDLE;
        endcase
    end

    assign bus.in_ready = (state_q == IDLE);
    assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: three instances (even parity, odd parity, no parity)
// checked cycle by cycle against a frame model built from the framing rules.
module tb_serial_frame_tx;
    localparam int DW  = 8;
    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] data_d [3];
    logic          valid_d[3];
    logic          tx_w   [3];
    logic          busy_w [3];
    logic          ready_w[3];

    logic obs_tx  [256];
    logic obs_busy[256];
    logic obs_rdy [256];

    serial_frame_tx_if #(.DATA_W(DW)) bus0 ();
    serial_frame_tx_if #(.DATA_W(DW)) bus1 ();
    serial_frame_tx_if #(.DATA_W(DW)) bus2 ();

    assign bus0.in_data = data_d[0];  assign bus0.in_valid = valid_d[0];
    assign bus1.in_data = data_d[1];  assign bus1.in_valid = valid_d[1];
    assign bus2.in_data = data_d[2];  assign bus2.in_valid = valid_d[2];
    assign tx_w[0] = bus0.tx_out;  assign busy_w[0] = bus0.busy;  assign ready_w[0] = bus0.in_ready;
    assign tx_w[1] = bus1.tx_out;  assign busy_w[1] = bus1.busy;  assign ready_w[1] = bus1.in_ready;
    assign tx_w[2] = bus2.tx_out;  assign busy_w[2] = bus2.busy;  assign ready_w[2] = bus2.in_ready;

    serial_frame_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0))
        dut_even (.clk(clk), .rst_n(rst_n), .bus(bus0));
    serial_frame_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1))
        dut_odd  (.clk(clk), .rst_n(rst_n), .bus(bus1));
    serial_frame_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0))
        dut_nopar(.clk(clk), .rst_n(rst_n), .bus(bus2));

    function automatic int pen(input int k);
        return (k == 2) ? 0 : 1;
    endfunction

    function automatic int pod(input int k);
        return (k == 1) ? 1 : 0;
    endfunction

    function automatic int frame_len(input int k);
        return (2 + DW + pen(k)) * CPB;
    endfunction

    // Bit idx of the frame: 0 start, 1..DW data LSB first, then parity (if any), then stop.
    function automatic logic exp_bit(input int k, input logic [DW-1:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= DW) return d[idx-1];
        if (pen(k) != 0 && idx == DW + 1) return ((($countones(d) + pod(k)) % 2) == 1);
        return 1'b1;
    endfunction

    task automatic start_frame(input int k, input logic [DW-1:0] d, input bit hold, output bit ok);
        int waited = 0;
        @(negedge clk);
        while (ready_w[k] !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        ok = (ready_w[k] === 1'b1);
        data_d[k]  = d;
        valid_d[k] = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) valid_d[k] = 1'b0;
    endtask

    // Sample n cycles after the accepting edge; optionally scramble the inputs meanwhile.
    task automatic capture(input int k, input int n, input bit disturb, input int drop_at);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            obs_tx[c]   = tx_w[k];
            obs_busy[c] = busy_w[k];
            obs_rdy[c]  = ready_w[k];
            if (c == drop_at) valid_d[k] = 1'b0;
            if (disturb) begin
                if (c < frame_len(k) - 3) begin
                    valid_d[k] = 1'($urandom_range(0, 1));
                    data_d[k]  = DW'($urandom);
                end else begin
                    valid_d[k] = 1'b0;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (tx_w[k] !== 1'b1 || busy_w[k] !== 1'b0 || ready_w[k] !== 1'b1) begin
                n_fail++;
                $display("FAIL reset dut%0d: tx=%b busy=%b ready=%b, required tx=1 busy=0 ready=1",
                         k, tx_w[k], busy_w[k], ready_w[k]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_frames();
        int            ks[11];
        logic [DW-1:0] ds[11];
        ks[0] = 0; ds[0] = 8'hA5;
        ks[1] = 1; ds[1] = 8'hFF;
        ks[2] = 1; ds[2] = 8'h00;
        ks[3] = 0; ds[3] = 8'h01;
        ks[4] = 2; ds[4] = 8'h3C;
        for (int i = 5; i < 11; i++) begin
            ks[i] = int'($urandom_range(0, 2));
            ds[i] = DW'($urandom);
        end
        for (int i = 0; i < 11; i++) begin
            bit ok;
            int f;
            f = frame_len(ks[i]);
            start_frame(ks[i], ds[i], 1'b0, ok);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL frame_ready dut%0d: in_ready never rose, required 1", ks[i]);
            end
            capture(ks[i], f + 1, 1'b0, -1);
            for (int c = 0; c <= f; c++) begin
                logic et, eb;
                et = (c < f) ? exp_bit(ks[i], ds[i], c / CPB) : 1'b1;
                eb = (c < f);
                n_checks++;
                if (obs_tx[c] !== et || obs_busy[c] !== eb || obs_rdy[c] !== !eb) begin
                    n_fail++;
                    $display("FAIL frame dut%0d data=%h cycle %0d: tx=%b busy=%b ready=%b, required tx=%b busy=%b ready=%b",
                             ks[i], ds[i], c, obs_tx[c], obs_busy[c], obs_rdy[c], et, eb, !eb);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int f;
        f = frame_len(0);
        start_frame(0, 8'h55, 1'b1, ok);
        data_d[0] = 8'hAA;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL b2b_ready: in_ready never rose, required 1");
        end
        capture(0, 3 * f + 1, 1'b0, f + 1);
        for (int c = 0; c < 3 * f + 1; c++) begin
            logic et, eb;
            if (c < f) begin
                et = exp_bit(0, 8'h55, c / CPB); eb = 1'b1;
            end else if (c > f && c <= 2 * f) begin
                et = exp_bit(0, 8'hAA, (c - f - 1) / CPB); eb = 1'b1;
            end else begin
                et = 1'b1; eb = 1'b0;
            end
            n_checks++;
            if (obs_tx[c] !== et || obs_busy[c] !== eb || obs_rdy[c] !== !eb) begin
                n_fail++;
                $display("FAIL back_to_back cycle %0d: tx=%b busy=%b ready=%b, required tx=%b busy=%b ready=%b",
                         c, obs_tx[c], obs_busy[c], obs_rdy[c], et, eb, !eb);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int f;
        f = frame_len(0);
        start_frame(0, DW'($urandom), 1'b0, ok);
        capture(0, (1 + 3) * CPB + 2, 1'b0, -1);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || ready_w[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_frame: tx=%b busy=%b ready=%b, required tx=1 busy=0 ready=1",
                     tx_w[0], busy_w[0], ready_w[0]);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: tx=%b busy=%b, required tx=1 busy=0", tx_w[0], busy_w[0]);
        end
        rst_n = 1'b1;
        start_frame(0, 8'h81, 1'b0, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL reset_restart_ready: in_ready never rose, required 1");
        end
        capture(0, f + 1, 1'b0, -1);
        for (int c = 0; c <= f; c++) begin
            logic et, eb;
            et = (c < f) ? exp_bit(0, 8'h81, c / CPB) : 1'b1;
            eb = (c < f);
            n_checks++;
            if (obs_tx[c] !== et || obs_busy[c] !== eb || obs_rdy[c] !== !eb) begin
                n_fail++;
                $display("FAIL reset_restart cycle %0d: tx=%b busy=%b ready=%b, required tx=%b busy=%b ready=%b",
                         c, obs_tx[c], obs_busy[c], obs_rdy[c], et, eb, !eb);
            end
        end
    endtask

    task automatic test_ignore_while_busy();
        for (int rep = 0; rep < 3; rep++) begin
            bit            ok;
            int            f;
            logic [DW-1:0] d;
            f = frame_len(rep);
            d = DW'($urandom);
            start_frame(rep, d, 1'b0, ok);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL ignore_ready dut%0d: in_ready never rose, required 1", rep);
            end
            capture(rep, 2 * f, 1'b1, -1);
            for (int c = 0; c < 2 * f; c++) begin
                logic et, eb;
                et = (c < f) ? exp_bit(rep, d, c / CPB) : 1'b1;
                eb = (c < f);
                n_checks++;
                if (obs_tx[c] !== et || obs_busy[c] !== eb || obs_rdy[c] !== !eb) begin
                    n_fail++;
                    $display("FAIL ignore_busy dut%0d cycle %0d: tx=%b busy=%b ready=%b, required tx=%b busy=%b ready=%b",
                             rep, c, obs_tx[c], obs_busy[c], obs_rdy[c], et, eb, !eb);
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            data_d[k]  = '0;
            valid_d[k] = 1'b0;
        end
        test_reset();
        test_frames();
        test_back_to_back();
        test_reset_mid_frame();
        test_ignore_while_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
